// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced mode/inc/cancel buttons drive an hour/min/sec editor
// that loads the live counters through one-cycle strobes. Define TIME_SET_DEC_EN to add btn_dec.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned HOUR_MOD        = 24,
  parameter int unsigned MS_MOD          = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_cancel,
`ifdef TIME_SET_DEC_EN
  input  logic       btn_dec,
`endif
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic       run_en,
  output logic       modify_hour,
  output logic       modify_min,
  output logic       modify_sec,
  output logic [7:0] modified_value,
  output logic [1:0] edit_field,
  output logic [7:0] edit_value
);

`ifdef TIME_SET_DEC_EN
  localparam int unsigned NB = 4;
`else
  localparam int unsigned NB = 3;
`endif
  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0]     HOUR_LIM = 9'(HOUR_MOD);
  localparam logic [8:0]     MS_LIM   = 9'(MS_MOD);
  localparam logic [7:0]     HOUR_MAX = 8'(HOUR_MOD - 1);
  localparam logic [7:0]     MS_MAX   = 8'(MS_MOD - 1);

  typedef enum logic [1:0] {IDLE, SET_HOUR, SET_MIN, SET_SEC} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_HOUR, PEND_MIN, PEND_SEC} pend_t;

  logic [NB-1:0] raw, sync1, sync2, stable, stable_d, press;
  logic [CW-1:0] cnt [NB];

`ifdef TIME_SET_DEC_EN
  assign raw = {btn_dec, btn_cancel, btn_inc, btn_mode};
`else
  assign raw = {btn_cancel, btn_inc, btn_mode};
`endif

  // A level is accepted only after it differs from the accepted level for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = stable & ~stable_d;

  logic ev_mode, ev_inc, ev_cancel;
  assign ev_mode   = press[0];
  assign ev_inc    = press[1];
  assign ev_cancel = press[2];
`ifdef TIME_SET_DEC_EN
  logic ev_dec;
  assign ev_dec = press[3];
`endif

  function automatic logic [7:0] clamp(input logic [7:0] v, input logic [8:0] lim);
    return ({1'b0, v} >= lim) ? '0 : v;
  endfunction

  state_t     state;
  pend_t      pend;
  logic [7:0] fmax;

  always_comb begin
    fmax = MS_MAX;
    if (state == SET_HOUR) fmax = HOUR_MAX;
  end

  // The load value is registered on the commit edge and the strobe follows one cycle later,
  // so modified_value is already settled the cycle before the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pend           <= PEND_NONE;
      run_en         <= 1'b1;
      modify_hour    <= 1'b0;
      modify_min     <= 1'b0;
      modify_sec     <= 1'b0;
      modified_value <= '0;
      edit_value     <= '0;
      edit_field     <= 2'd0;
    end else begin
      modify_hour <= (pend == PEND_HOUR);
      modify_min  <= (pend == PEND_MIN);
      modify_sec  <= (pend == PEND_SEC);
      pend        <= PEND_NONE;
      if (pend == PEND_SEC) run_en <= 1'b1;

      case (state)
        IDLE: begin
          if (ev_mode) begin
            edit_value <= clamp(cur_hour, HOUR_LIM);
            state      <= SET_HOUR;
            edit_field <= 2'd1;
            run_en     <= 1'b0;
          end
        end
        default: begin
          if (ev_cancel) begin
            state      <= IDLE;
            edit_field <= 2'd0;
            run_en     <= 1'b1;
          end else if (ev_mode) begin
            modified_value <= edit_value;
            case (state)
              SET_HOUR: begin
                pend       <= PEND_HOUR;
                edit_value <= clamp(cur_min, MS_LIM);
                state      <= SET_MIN;
                edit_field <= 2'd2;
              end
              SET_MIN: begin
                pend       <= PEND_MIN;
                edit_value <= clamp(cur_sec, MS_LIM);
                state      <= SET_SEC;
                edit_field <= 2'd3;
              end
              default: begin
                pend       <= PEND_SEC;
                state      <= IDLE;
                edit_field <= 2'd0;
              end
            endcase
          end else if (ev_inc) begin
            edit_value <= (edit_value == fmax) ? '0 : edit_value + 8'd1;
          end
`ifdef TIME_SET_DEC_EN
          else if (ev_dec) begin
            edit_value <= (edit_value == '0) ? fmax : edit_value - 8'd1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a field/value model predicts edit state and commit strobes.
module tb_time_set_ctrl;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_cancel = 1'b0, btn_dec = 1'b0;
  logic [7:0] cur_hour = '0, cur_min = '0, cur_sec = '0;
  logic       run_en, modify_hour, modify_min, modify_sec;
  logic [7:0] modified_value, edit_value;
  logic [1:0] edit_field;

  time_set_ctrl #(.DEBOUNCE_CYCLES(DB), .HOUR_MOD(24), .MS_MOD(60)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_cancel(btn_cancel),
`ifdef TIME_SET_DEC_EN
    .btn_dec(btn_dec),
`endif
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .run_en(run_en), .modify_hour(modify_hour), .modify_min(modify_min), .modify_sec(modify_sec),
    .modified_value(modified_value), .edit_field(edit_field), .edit_value(edit_value)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_field_q[$];
  int exp_value_q[$];
  int m_field = 0;
  int m_val   = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int fmod(input int f);
    return (f == 1) ? 24 : 60;
  endfunction

  function automatic int clampv(input int v, input int m);
    return (v >= m) ? 0 : v;
  endfunction

  // mask bits: 0 mode, 1 inc, 2 cancel, 3 dec; only the highest-priority event acts.
  task automatic model_apply(input logic [3:0] mask);
    if (m_field == 0) begin
      if (mask[0]) begin
        m_field = 1;
        m_val   = clampv(int'(cur_hour), 24);
      end
    end else if (mask[2]) begin
      m_field = 0;
    end else if (mask[0]) begin
      exp_field_q.push_back(m_field);
      exp_value_q.push_back(m_val);
      case (m_field)
        1: begin m_field = 2; m_val = clampv(int'(cur_min), 60); end
        2: begin m_field = 3; m_val = clampv(int'(cur_sec), 60); end
        default: m_field = 0;
      endcase
    end else if (mask[1]) begin
      m_val = (m_val + 1) % fmod(m_field);
    end else if (mask[3]) begin
      m_val = (m_val + fmod(m_field) - 1) % fmod(m_field);
    end
  endtask

  task automatic drive(input logic [3:0] mask);
    btn_mode   = mask[0];
    btn_inc    = mask[1];
    btn_cancel = mask[2];
    btn_dec    = mask[3];
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    if (hold >= DB + 3) model_apply(mask);
    @(posedge clk); #1;
    drive(mask);
    repeat (hold) @(posedge clk);
    #1;
    drive(4'b0000);
    repeat (DB + 6) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".edit_field"}, int'(edit_field), m_field);
    chk({tag, ".run_en"}, int'(run_en), (m_field == 0) ? 1 : 0);
    if (m_field != 0) chk({tag, ".edit_value"}, int'(edit_value), m_val);
  endtask

  task automatic monitor();
    logic [7:0] prev_mv = '0;
    logic [7:0] strobe_val = '0;
    logic       prev_strobe = 1'b0;
    logic       after = 1'b0;
    int         n, f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_strobe = 1'b0;
        after       = 1'b0;
        prev_mv     = modified_value;
        continue;
      end
      n = int'(modify_hour) + int'(modify_min) + int'(modify_sec);
      if (after) begin
        chk("mv_stable_after", int'(modified_value), int'(strobe_val));
        after = 1'b0;
      end
      if (n != 0) begin
        chk("strobe_onehot", n, 1);
        chk("strobe_width", int'(prev_strobe), 0);
        chk("mv_stable_before", int'(modified_value), int'(prev_mv));
        f = modify_hour ? 1 : (modify_min ? 2 : 3);
        if (exp_field_q.size() == 0) begin
          chk("unexpected_strobe_field", f, 0);
        end else begin
          chk("strobe_field", f, exp_field_q.pop_front());
          chk("strobe_value", int'(modified_value), exp_value_q.pop_front());
        end
        if (modify_sec) chk("run_en_with_sec_strobe", int'(run_en), 1);
        strobe_val = modified_value;
        after      = 1'b1;
      end
      prev_strobe = (n != 0);
      prev_mv     = modified_value;
    end
  endtask

  initial begin
    logic [3:0] mask;
    int         r;
    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset.run_en", int'(run_en), 1);
    chk("reset.edit_field", int'(edit_field), 0);
    chk("reset.edit_value", int'(edit_value), 0);
    chk("reset.modified_value", int'(modified_value), 0);
    chk("reset.strobes", int'({modify_hour, modify_min, modify_sec}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Hour 23 enters, then wraps to 0.
    cur_hour = 8'd23;
    press(4'b0001, DB + 4); check_state("enter23");
    press(4'b0010, DB + 4); check_state("wrap_hour");
    press(4'b0100, DB + 4); check_state("cancel_hour");

    // Full walk with 10/59/30 and two increments.
    cur_hour = 8'd10; cur_min = 8'd59; cur_sec = 8'd30;
    press(4'b0001, DB + 4); check_state("walk_enter");
    press(4'b0010, DB + 4);
    press(4'b0010, DB + 4); check_state("walk_inc");
    press(4'b0001, DB + 4); check_state("walk_min");
    press(4'b0001, DB + 4); check_state("walk_sec");
    press(4'b0001, DB + 4); check_state("walk_done");

    // Glitch ignored, long hold gives a single increment.
    cur_hour = 8'd5;
    press(4'b0001, DB + 4);
    press(4'b0010, 2);   check_state("glitch");
    press(4'b0010, 100); check_state("long_hold");

    // Cancel and mode debounced together in SET_MIN: cancel wins.
    press(4'b0001, DB + 4); check_state("to_min");
    press(4'b0101, DB + 4); check_state("cancel_beats_mode");

    // Clamp of out-of-range captures.
    cur_hour = 8'd30; cur_min = 8'd200; cur_sec = 8'd60;
    press(4'b0001, DB + 4); check_state("clamp_hour");
    press(4'b0001, DB + 4); check_state("clamp_min");
    press(4'b0001, DB + 4); check_state("clamp_sec");

    // Asynchronous reset in SET_SEC discards the edit.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midreset.run_en", int'(run_en), 1);
    chk("midreset.edit_field", int'(edit_field), 0);
    chk("midreset.edit_value", int'(edit_value), 0);
    chk("midreset.modified_value", int'(modified_value), 0);
    chk("midreset.strobes", int'({modify_hour, modify_min, modify_sec}), 0);
    m_field = 0;
    exp_field_q.delete();
    exp_value_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_state("after_reset");

`ifdef TIME_SET_DEC_EN
    cur_hour = 8'd1; cur_min = 8'd0;
    press(4'b0001, DB + 4);
    press(4'b0001, DB + 4); check_state("dec_setup");
    press(4'b1000, DB + 4); check_state("dec_wrap");
    press(4'b1010, DB + 4); check_state("inc_beats_dec");
    press(4'b0100, DB + 4);
`endif

    for (int i = 0; i < 150; i++) begin
      cur_hour = 8'($urandom_range(0, 31));
      cur_min  = 8'($urandom_range(0, 70));
      cur_sec  = 8'($urandom_range(0, 70));
      if ($urandom_range(0, 15) == 0) cur_min = 8'hFF;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: mask = 4'b0001;
        3, 4, 5, 6: mask = 4'b0010;
        7: mask = 4'b0100;
`ifdef TIME_SET_DEC_EN
        8: mask = 4'b1000;
        default: mask = 4'($urandom_range(1, 15));
`else
        8: mask = 4'b0010;
        default: mask = 4'($urandom_range(1, 7));
`endif
      endcase
      press(mask, DB + 4 + int'($urandom_range(0, 6)));
      check_state("random");
    end

    repeat (10) @(posedge clk);
    chk("queue_drained", exp_field_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
